// File: rtl/fp_compress_pkg.sv
// Shared types and constants for the 12-bit to 1/3/4 sign-exponent-fraction compressor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fp_compress_pkg;

    localparam int DATA_W = 12;
    localparam int EXP_W  = 3;
    localparam int FRAC_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    localparam logic [EXP_W-1:0]  E_MAX = 3'd7;
    localparam logic [FRAC_W-1:0] F_MAX = 4'd15;

    // Most negative sample; folded onto -2047 so its magnitude fits 11 bits.
    localparam logic [DATA_W-1:0] DATA_MIN = 12'h800;

endpackage

// File: rtl/fp_compress_arb_if.sv
// Bundle of both requester channels and the result channel of fp_compress_arb.
// Latency: n/a (wires only); optional out_sat exists when FPC_SAT_FLAG_EN is defined.
// Backpressure: valid/ready on each channel; master drives valids and out_ready.
interface fp_compress_arb_if;
    import fp_compress_pkg::*;

    logic                a_valid;
    logic [DATA_W-1:0]   a_data;
    logic                a_ready;
    logic                b_valid;
    logic [DATA_W-1:0]   b_data;
    logic                b_ready;
    logic                out_valid;
    logic                out_ready;
    logic                out_s;
    logic [EXP_W-1:0]    out_e;
    logic [FRAC_W-1:0]   out_f;
    logic                out_id;
`ifdef FPC_SAT_FLAG_EN
    logic                out_sat;
`endif

    // Requesters and result consumer.
    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_s, out_e, out_f, out_id
`ifdef FPC_SAT_FLAG_EN
        , input out_sat
`endif
    );

    // The arbiter itself.
    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_s, out_e, out_f, out_id
`ifdef FPC_SAT_FLAG_EN
        , output out_sat
`endif
    );

endinterface

// File: rtl/fp_compress_core.sv
// Combinational 12-bit two's-complement to sign / 3-bit exponent / 4-bit fraction compressor.
// Latency: 0 cycles; sat output exists only when FPC_SAT_FLAG_EN is defined.
// Backpressure: none (pure function of data).
module fp_compress_core
    import fp_compress_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic              s,
    output logic [EXP_W-1:0]  e,
    output logic [FRAC_W-1:0] f
`ifdef FPC_SAT_FLAG_EN
    , output logic            sat
`endif
);

    logic [DATA_W-2:0] lo;
    logic [DATA_W-2:0] mag;
    logic [EXP_W-1:0]  e_raw;
    logic [FRAC_W-1:0] f_raw;
    logic              rnd;
    logic [FRAC_W:0]   sum;
    logic              sat_rnd;

    // Magnitude, leading-one normalisation and round-half-up with saturation.
    always_comb begin
        s     = data[DATA_W-1];
        // -2048 is folded onto -2047; only the low bits matter after negation.
        lo    = (data == DATA_MIN) ? 11'h001 : data[DATA_W-2:0];
        mag   = s ? (~lo + 11'd1) : lo;
        e_raw = '0;
        f_raw = mag[FRAC_W-1:0];
        rnd   = 1'b0;
        // Ascending scan: the last hit is the leading one.
        for (int i = FRAC_W; i < DATA_W - 1; i++) begin
            if (mag[i]) begin
                e_raw = EXP_W'(i - 3);
                f_raw = mag[i -: FRAC_W];
                rnd   = mag[i - FRAC_W];
            end
        end
        sum     = {1'b0, f_raw} + {{FRAC_W{1'b0}}, rnd};
        sat_rnd = 1'b0;
        e       = e_raw;
        f       = sum[FRAC_W-1:0];
        if (sum[FRAC_W]) begin
            if (e_raw == E_MAX) begin
                e       = E_MAX;
                f       = F_MAX;
                sat_rnd = 1'b1;
            end else begin
                e = e_raw + 3'd1;
                f = 4'b1000;
            end
        end
    end

`ifdef FPC_SAT_FLAG_EN
    assign sat = sat_rnd || (data == DATA_MIN);
`endif

endmodule

// File: rtl/fp_compress_arb.sv
// Round-robin two-input arbiter feeding one fp_compress_core; result held until consumed.
// Latency: result valid 2 cycles after accept; 1 sample per 3 cycles peak (FPC_SAT_FLAG_EN adds out_sat).
// Backpressure: inputs are refused outside IDLE; result held stable while out_ready is low.
module fp_compress_arb
    import fp_compress_pkg::*;
#(
    parameter bit RR_START = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    fp_compress_arb_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_CONV = 2'(CONV);
    localparam logic [1:0] ST_HOLD = 2'(HOLD);

    logic [1:0]        state;
    logic              prio;
    logic [DATA_W-1:0] din_q;
    logic              id_q;
    logic              a_hs;
    logic              b_hs;

    logic              c_s;
    logic [EXP_W-1:0]  c_e;
    logic [FRAC_W-1:0] c_f;

    logic              out_valid_q;
    logic              out_s_q;
    logic [EXP_W-1:0]  out_e_q;
    logic [FRAC_W-1:0] out_f_q;
    logic              out_id_q;
`ifdef FPC_SAT_FLAG_EN
    logic              c_sat;
    logic              out_sat_q;
`endif

    // Grant only in IDLE and never during reset; contention resolved by prio.
    always_comb begin
        bus.a_ready = 1'b0;
        bus.b_ready = 1'b0;
        if (!rst && state == ST_IDLE) begin
            bus.a_ready = bus.a_valid && (!bus.b_valid || prio == ID_A);
            bus.b_ready = bus.b_valid && (!bus.a_valid || prio == ID_B);
        end
    end

    assign a_hs = bus.a_valid && bus.a_ready;
    assign b_hs = bus.b_valid && bus.b_ready;

    fp_compress_core u_core (
        .data (din_q),
        .s    (c_s),
        .e    (c_e),
        .f    (c_f)
`ifdef FPC_SAT_FLAG_EN
        , .sat (c_sat)
`endif
    );

    // Accept in IDLE, capture the conversion in CONV, hold the result until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            prio        <= RR_START;
            din_q       <= '0;
            id_q        <= ID_A;
            out_valid_q <= 1'b0;
            out_s_q     <= 1'b0;
            out_e_q     <= '0;
            out_f_q     <= '0;
            out_id_q    <= ID_A;
`ifdef FPC_SAT_FLAG_EN
            out_sat_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (a_hs || b_hs) begin
                        din_q <= a_hs ? bus.a_data : bus.b_data;
                        id_q  <= a_hs ? ID_A : ID_B;
                        prio  <= ~prio;
                        state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    out_s_q     <= c_s;
                    out_e_q     <= c_e;
                    out_f_q     <= c_f;
                    out_id_q    <= id_q;
`ifdef FPC_SAT_FLAG_EN
                    out_sat_q   <= c_sat;
`endif
                    out_valid_q <= 1'b1;
                    state       <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_s     = out_s_q;
    assign bus.out_e     = out_e_q;
    assign bus.out_f     = out_f_q;
    assign bus.out_id    = out_id_q;
`ifdef FPC_SAT_FLAG_EN
    assign bus.out_sat   = out_sat_q;
`endif

endmodule

// File: doc/fp_compress_arb.md
FP_COMPRESS_ARB -- requirements
Module: fp_compress_arb

Interface
REQ-001 Parameter: RR_START, 0, requester index (0=A, 1=B) that wins the first contention after reset.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 a_valid  in  1  requester A sample present.
REQ-005 a_data  in  12  requester A two's-complement sample.
REQ-006 a_ready  out  1  A sample accepted this cycle when a_valid&&a_ready.
REQ-007 b_valid / b_data / b_ready  in/in/out  1/12/1  requester B, same as A.
REQ-008 out_valid  out  1  result held valid.
REQ-009 out_ready  in  1  consumer accepts result when out_valid&&out_ready.
REQ-010 out_s / out_e / out_f  out  1/3/4  sign, exponent, significand of result.
REQ-011 out_id  out  1  source of result (0=A, 1=B).

Function
REQ-012 FSM states IDLE, CONV, HOLD; IDLE->CONV on any input handshake; CONV->HOLD unconditionally; HOLD->IDLE on output handshake.
REQ-013 a_ready/b_ready combinational; nonzero only in IDLE; at most one high; a_ready=a_valid&&(!b_valid||prio==A), b_ready likewise.
REQ-014 Round-robin: prio toggles to the other requester after every accepted sample; prio reset value = RR_START.
REQ-015 Accepted sample and its id registered at handshake edge; conversion result registered at CONV edge; out_valid high first cycle after that, i.e. 2 cycles after accept.
REQ-016 out_valid, out_s/e/f, out_id stable throughout HOLD until out_ready; no new accept while CONV or HOLD; peak throughput 1 sample per 3 cycles.
REQ-017 Sign-magnitude: out_s=data[11]; 0x800 treated as 0x801 (magnitude 2047); magnitude m = two's-complement negation when negative.
REQ-018 Normalise: m<16 -> E=0, F=m[3:0], round bit 0; else E=(MSB position of m)-3, F=4 bits from MSB down, round bit = next lower bit.
REQ-019 Rounding: F+round computed 5 bits wide; carry -> E+1, F=4'b1000; carry with E=7 -> saturate E=7, F=15.
REQ-020 Output handshake and input handshake may not coincide (different states); simultaneous a_valid/b_valid resolved solely by prio.
REQ-021 Deasserting a_valid/b_valid before acceptance is legal; no state change.

Reset
REQ-022 rst asserted at any time, including CONV/HOLD: state=IDLE, out_valid=0, out_s=0, out_e=0, out_f=0, out_id=0, prio=RR_START immediately, in-flight sample discarded.
REQ-023 a_ready=b_ready=0 while rst high.

Configuration
REQ-024 Macro FPC_SAT_FLAG_EN defined: extra output out_sat (1 bit), registered with result, high when saturation of REQ-019 occurred or input was 0x800; reset 0.
REQ-025 Macro absent: out_sat port and its logic do not exist; all other behaviour identical.

Structure
REQ-026 Shared package fp_compress_pkg holds: state enum (IDLE/CONV/HOLD), widths (DATA_W=12, EXP_W=3, FRAC_W=4), requester id constants ID_A/ID_B, E_MAX=7, F_MAX=15.
REQ-027 One combinational sub-module fp_compress_core (12-bit in -> S,E,F and saturation flag) instantiated once; the arbiter contains FSM, prio register, and input/output registers.

Verification
REQ-028 A sends 0x02D (+45), out_ready=1 -> out_valid 2 cycles after accept; S=0,E=2,F=11,id=0.
REQ-029 B sends 0x03E (+62) -> S=0,E=3,F=8 (rounding carry); 0xFD3 (-45) -> S=1,E=2,F=11.
REQ-030 A sends 0x7FF then 0x800 -> both E=7,F=15, S=0 then S=1; out_sat=1 both when FPC_SAT_FLAG_EN defined.
REQ-031 After reset (RR_START=0), a_valid and b_valid high continuously with distinct data -> results alternate id 0,1,0,1; a_ready and b_ready never high together.
REQ-032 out_ready low 5 cycles in HOLD -> out fields unchanged, a_ready=b_ready=0; rst pulse in HOLD -> out_valid 0 same cycle, next accept goes to RR_START requester.
